// File: rtl/mtx_types_pkg.sv
// Shared types for the matrix-unit fabric: beat payload, unit ids and
// the write arbiter's state encoding.
package mtx_types;

  localparam int N_UNITS = 32;

  typedef logic [31:0] mv_t;
  typedef logic [4:0]  unit_id_t;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_priority_picker.sv
// Rotating-priority search: the first set request bit at or after rr_ptr
// (wrapping) wins.
module rr_priority_picker #(
  parameter int N_UNITS = 32,
  parameter int ID_W    = 5
) (
  input  logic [N_UNITS-1:0] req,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [ID_W-1:0]    winner,
  output logic               any_req
);

  logic [ID_W-1:0] idx;

  // Scan from the farthest offset down to zero so the nearest hit overwrites.
  always_comb begin
    winner  = '0;
    any_req = 1'b0;
    idx     = '0;
    for (int k = N_UNITS - 1; k >= 0; k--) begin
      idx = rr_ptr + ID_W'(k);
      if (req[idx]) begin
        winner  = idx;
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/shared_mem_write_arbiter.sv
// Round-robin burst arbiter serialising matrix-unit beats onto the single
// shared-memory write port, with bursts capped at MAX_BURST beats.
module shared_mem_write_arbiter
  import mtx_types::*;
#(
  parameter int N_UNITS   = mtx_types::N_UNITS,
  parameter int ID_W      = $clog2(N_UNITS),
  parameter int DATA_W    = $bits(mv_t),
  parameter int MAX_BURST = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_UNITS-1:0]         req,
  input  logic [N_UNITS-1:0]         last,
  input  logic [N_UNITS*DATA_W-1:0]  data,
  input  logic                       mem_ready,
  output logic [N_UNITS-1:0]         gnt,
  output logic [ID_W-1:0]            write_unit_id,
  output logic [DATA_W-1:0]          write_data,
  output logic                       write_enable,
  output logic                       busy
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

  arb_state_t       state, next_state;
  logic [ID_W-1:0]  rr_ptr, next_rr_ptr;
  logic [ID_W-1:0]  owner, next_owner;
  logic [CNT_W-1:0] beat_cnt, next_beat_cnt;

  logic [ID_W-1:0]   winner;
  logic              any_req;
  logic              xfer;
  logic [ID_W-1:0]   xfer_id;
  logic [DATA_W-1:0] beat_data;

  rr_priority_picker #(
    .N_UNITS (N_UNITS),
    .ID_W    (ID_W)
  ) u_picker (
    .req     (req),
    .rr_ptr  (rr_ptr),
    .winner  (winner),
    .any_req (any_req)
  );

  // Only the owner can transfer during a burst; everyone else waits for IDLE.
  always_comb begin
    next_state    = state;
    next_rr_ptr   = rr_ptr;
    next_owner    = owner;
    next_beat_cnt = beat_cnt;
    xfer          = 1'b0;
    xfer_id       = winner;
    gnt           = '0;
    case (state)
      IDLE: begin
        if (!rst && mem_ready && any_req) begin
          xfer    = 1'b1;
          xfer_id = winner;
          if (last[winner] || MAX_BURST == 1) begin
            next_rr_ptr = winner + 1'b1;
          end else begin
            next_state    = BURST;
            next_owner    = winner;
            next_beat_cnt = CNT_W'(1);
          end
        end
      end
      BURST: begin
        if (!rst && mem_ready && req[owner]) begin
          xfer    = 1'b1;
          xfer_id = owner;
          if (last[owner] || (beat_cnt + 1'b1) == MAX_CNT) begin
            next_state    = IDLE;
            next_rr_ptr   = owner + 1'b1;
            next_beat_cnt = '0;
          end else begin
            next_beat_cnt = beat_cnt + 1'b1;
          end
        end
      end
      default: next_state = IDLE;
    endcase
    gnt[xfer_id] = xfer;
    beat_data    = data[xfer_id*DATA_W +: DATA_W];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      owner         <= '0;
      beat_cnt      <= '0;
      write_enable  <= 1'b0;
      write_unit_id <= '0;
      write_data    <= '0;
    end else begin
      state        <= next_state;
      rr_ptr       <= next_rr_ptr;
      owner        <= next_owner;
      beat_cnt     <= next_beat_cnt;
      write_enable <= xfer;
      if (xfer) begin
        write_unit_id <= xfer_id;
        write_data    <= beat_data;
      end
    end
  end

  assign busy = (state == BURST);

endmodule

// File: tb/tb_shared_mem_write_arbiter.sv
// Directed bench for shared_mem_write_arbiter: single beats, round robin,
// forced burst release, backpressure, owner stall and reset mid-burst.
module tb_shared_mem_write_arbiter;

  localparam int N  = 32;
  localparam int DW = 32;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req;
  logic [N-1:0]    last;
  logic [N*DW-1:0] data;
  logic            mem_ready;
  logic [N-1:0]    gnt;
  logic [4:0]      write_unit_id;
  logic [DW-1:0]   write_data;
  logic            write_enable;
  logic            busy;

  int total_checks = 0;
  int fail_count   = 0;

  shared_mem_write_arbiter dut (
    .clk           (clk),
    .rst           (rst),
    .req           (req),
    .last          (last),
    .data          (data),
    .mem_ready     (mem_ready),
    .gnt           (gnt),
    .write_unit_id (write_unit_id),
    .write_data    (write_data),
    .write_enable  (write_enable),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [63:0] actual,
                              input logic [63:0] expected);
    total_checks++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N-1:0] bit_of(input int id);
    logic [N-1:0] v;
    v = '0;
    v[id] = 1'b1;
    return v;
  endfunction

  // Grant must be settled combinationally before the edge, then one beat out.
  task automatic expect_beat(input string tag, input int id);
    #1;
    check_output({tag, " gnt"}, 64'(gnt), 64'(bit_of(id)));
    tick();
    check_output({tag, " we"}, 64'(write_enable), 64'd1);
    check_output({tag, " id"}, 64'(write_unit_id), 64'(id));
    check_output({tag, " data"}, 64'(write_data), 64'(32'h100 + id));
  endtask

  initial begin
    rst       = 1'b1;
    req       = '0;
    last      = '0;
    mem_ready = 1'b0;
    for (int i = 0; i < N; i++) data[i*DW +: DW] = 32'h100 + i;

    tick();
    req       = bit_of(3);
    mem_ready = 1'b1;
    #1;
    check_output("gnt during rst", 64'(gnt), 64'd0);
    tick();
    check_output("rst we", 64'(write_enable), 64'd0);
    check_output("rst id", 64'(write_unit_id), 64'd0);
    check_output("rst data", 64'(write_data), 64'd0);
    check_output("rst busy", 64'(busy), 64'd0);

    // Single beat from unit 3
    rst = 1'b0;
    last = bit_of(3);
    data[3*DW +: DW] = 32'hA5;
    #1;
    check_output("single gnt", 64'(gnt), 64'(bit_of(3)));
    tick();
    req = '0;
    check_output("single we", 64'(write_enable), 64'd1);
    check_output("single id", 64'(write_unit_id), 64'd3);
    check_output("single data", 64'(write_data), 64'hA5);
    check_output("single rr_ptr", 64'(dut.rr_ptr), 64'd4);
    data[3*DW +: DW] = 32'h103;

    // Round robin across 0, 5, 31 from rr_ptr 4
    req  = bit_of(0) | bit_of(5) | bit_of(31);
    last = req;
    expect_beat("rr1", 5);
    expect_beat("rr2", 31);
    expect_beat("rr3", 0);
    expect_beat("rr4", 5);
    req = '0;
    tick();
    check_output("rr idle we", 64'(write_enable), 64'd0);

    // Move rr_ptr to 2 so unit 2 wins over unit 7
    req  = bit_of(1);
    last = bit_of(1);
    expect_beat("pre1", 1);

    // Forced release after 8 beats
    req  = bit_of(2) | bit_of(7);
    last = bit_of(7);
    for (int b = 1; b <= 8; b++) begin
      #1;
      check_output($sformatf("burst%0d busy", b), 64'(busy), 64'(b > 1));
      expect_beat($sformatf("burst%0d", b), 2);
    end
    check_output("post-burst busy", 64'(busy), 64'd0);
    expect_beat("after forced", 7);
    req  = '0;
    last = '0;
    tick();

    // Backpressure mid-burst from unit 10
    req = bit_of(10);
    expect_beat("bp1", 10);
    expect_beat("bp2", 10);
    mem_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      check_output("bp gnt", 64'(gnt), 64'd0);
      tick();
      check_output("bp we", 64'(write_enable), 64'd0);
      check_output("bp busy", 64'(busy), 64'd1);
      check_output("bp cnt", 64'(dut.beat_cnt), 64'd2);
    end
    mem_ready = 1'b1;
    expect_beat("bp resume", 10);
    last = bit_of(10);
    expect_beat("bp last", 10);
    check_output("bp end busy", 64'(busy), 64'd0);
    req  = '0;
    last = '0;

    // Owner stall: unit 13 owns, unit 9 must wait
    req = bit_of(13);
    expect_beat("stall start", 13);
    req = bit_of(9);
    for (int c = 0; c < 5; c++) begin
      #1;
      check_output("stall gnt", 64'(gnt), 64'd0);
      tick();
      check_output("stall busy", 64'(busy), 64'd1);
      check_output("stall we", 64'(write_enable), 64'd0);
    end
    req  = bit_of(13) | bit_of(9);
    last = bit_of(13) | bit_of(9);
    expect_beat("stall end", 13);
    expect_beat("stall wrap", 9);
    req  = '0;
    last = '0;

    // Reset on beat 3 of a burst from unit 12
    req = bit_of(12);
    expect_beat("rb1", 12);
    expect_beat("rb2", 12);
    rst = 1'b1;
    #1;
    check_output("rb gnt in rst", 64'(gnt), 64'd0);
    tick();
    check_output("rb busy", 64'(busy), 64'd0);
    check_output("rb we", 64'(write_enable), 64'd0);
    check_output("rb rr_ptr", 64'(dut.rr_ptr), 64'd0);
    rst = 1'b0;
    expect_beat("rb regrant", 12);
    check_output("rb new burst busy", 64'(busy), 64'd1);
    req = '0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             total_checks, fail_count);
    $finish;
  end

endmodule
